// File: rtl/wb_select_unit.sv
// Write-back select unit: chooses the register-file result source, aligns and
// extends load data, and turns loads that never return into an error pulse.
module wb_select_unit #(
  parameter int WIDTH       = 32,
  parameter int RAW         = 5,
  parameter int MEM_TIMEOUT = 15,
  localparam int LW         = $clog2(WIDTH / 8)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_sel_src,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic [WIDTH-1:0] i_pc_plus4,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [RAW-1:0]   i_rd_addr,
  input  logic             i_reg_wr,
  input  logic [1:0]       i_ld_size,
  input  logic             i_ld_unsigned,
  input  logic [LW-1:0]    i_addr_lo,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic [WIDTH-1:0] o_wb_data,
  output logic [RAW-1:0]   o_wb_rd,
  output logic             o_wb_we,
  output logic             o_wb_valid,
  output logic             o_err
);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;

  // Last wait cycle index: the load gives up once this many cycles pass without ack.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [RAW-1:0]   rd_q, rd_d;
  logic             reg_wr_q, reg_wr_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [RAW-1:0]   wb_rd_q, wb_rd_d;
  logic             wb_we_q, wb_we_d;
  logic             wb_valid_q, wb_valid_d;
  logic             err_q, err_d;

  logic [RAW-1:0]   ctx_rd;
  logic             ctx_wr;
  logic [1:0]       ctx_size;
  logic             ctx_uns;
  logic [LW-1:0]    ctx_lane;
  logic             mem_done;
  logic             finish_ok;
  logic             finish_err;
  logic [WIDTH-1:0] finish_data;

  // Aligned halves/words only ever start on their own boundary, so a plain
  // byte shift by the lane address lands every legal field at bit 0.
  function automatic logic [WIDTH-1:0] align_load(
    input logic [WIDTH-1:0] data,
    input logic [1:0]       size,
    input logic             uns,
    input logic [LW-1:0]    lane
  );
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] left;
    logic [6:0]       pad;
    shifted = data >> {lane, 3'b000};
    case (size)
      2'b00:   pad = 7'(WIDTH - 8);
      2'b01:   pad = 7'(WIDTH - 16);
      2'b10:   pad = 7'(WIDTH - 32);
      default: pad = 7'd0;
    endcase
    left = shifted << pad;
    if (uns) begin
      return left >> pad;
    end
    return $signed(left) >>> pad;
  endfunction

  function automatic logic misaligned(
    input logic [1:0]    size,
    input logic [LW-1:0] lane
  );
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      2'b10:   return lane[1:0] != 2'b00;
      default: return (WIDTH == 32) || (lane != '0);
    endcase
  endfunction

  // Next-state, context capture and write-back result selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    reg_wr_d    = reg_wr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = wb_we_q;
    wb_valid_d  = 1'b0;
    err_d       = 1'b0;
    mem_done    = 1'b0;
    finish_ok   = 1'b0;
    finish_err  = 1'b0;
    finish_data = '0;

    if (state_q == IDLE) begin
      ctx_rd   = i_rd_addr;
      ctx_wr   = i_reg_wr;
      ctx_size = i_ld_size;
      ctx_uns  = i_ld_unsigned;
      ctx_lane = i_addr_lo;
    end else begin
      ctx_rd   = rd_q;
      ctx_wr   = reg_wr_q;
      ctx_size = size_q;
      ctx_uns  = uns_q;
      ctx_lane = lane_q;
    end

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          rd_d     = i_rd_addr;
          reg_wr_d = i_reg_wr;
          size_d   = i_ld_size;
          uns_d    = i_ld_unsigned;
          lane_d   = i_addr_lo;
          if (i_sel_src != SRC_MEM) begin
            finish_ok = 1'b1;
            case (i_sel_src)
              SRC_ALU: finish_data = i_alu_out;
              SRC_PC4: finish_data = i_pc_plus4;
              default: finish_data = i_imm;
            endcase
          end else if (i_mem_ack) begin
            mem_done = 1'b1;
          end else begin
            state_d = WAIT_MEM;
            cnt_d   = '0;
          end
        end
      end
      WAIT_MEM: begin
        if (i_mem_ack) begin
          mem_done = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          finish_err = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (mem_done) begin
      if (misaligned(ctx_size, ctx_lane)) begin
        finish_err = 1'b1;
      end else begin
        finish_ok   = 1'b1;
        finish_data = align_load(i_rd_data, ctx_size, ctx_uns, ctx_lane);
      end
    end

    if (finish_ok) begin
      wb_valid_d = 1'b1;
      wb_data_d  = finish_data;
      wb_rd_d    = ctx_rd;
      wb_we_d    = ctx_wr && (ctx_rd != '0);
    end else if (finish_err) begin
      wb_valid_d = 1'b1;
      err_d      = 1'b1;
      wb_data_d  = '0;
      wb_rd_d    = ctx_rd;
      wb_we_d    = 1'b0;
    end
  end

  // State, captured load context and registered write-back outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      reg_wr_q   <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      lane_q     <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      reg_wr_q   <= reg_wr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_wb_data  = wb_data_q;
  assign o_wb_rd    = wb_rd_q;
  assign o_wb_we    = wb_we_q;
  assign o_wb_valid = wb_valid_q;
  assign o_err      = err_q;

endmodule
